// File: rtl/alu16_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Optional per-requester completion counters: define ALU16_ARB_PERF_CNT_EN.
module alu16_arbiter #(
  parameter int WIDTH   = 16,
  parameter int OPC_W   = 4,
  parameter int MAX_OPC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPC_W-1:0] req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPC_W-1:0] req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPC_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic             rsp_err
`ifdef ALU16_ARB_PERF_CNT_EN
  ,
  output logic [15:0]      perf_cnt0,
  output logic [15:0]      perf_cnt1
`endif
);

  localparam logic [OPC_W-1:0] L_MAX_OPC = OPC_W'(MAX_OPC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_ptr;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_legal;
  logic             w_done;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [OPC_W-1:0] r_op;
  logic             r_id;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_zero;
  logic             r_rsp_ovf;
  logic             r_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Pointer only breaks ties; a lone requester is always granted.
  always_comb begin
    w_next = r_state;
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0_valid && (!req1_valid || !r_ptr)) begin
          w_gnt0 = 1'b1;
          w_next = S_ISSUE;
        end else if (req1_valid) begin
          w_gnt1 = 1'b1;
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_legal = (r_op <= L_MAX_OPC);
  assign w_done  = (r_state == S_RESP) && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= '0;
      r_id <= 1'b0;
    end else if (w_gnt0 || w_gnt1) begin
      r_a  <= w_gnt1 ? req1_a  : req0_a;
      r_b  <= w_gnt1 ? req1_b  : req0_b;
      r_op <= w_gnt1 ? req1_op : req0_op;
      r_id <= w_gnt1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_zero  <= 1'b0;
      r_rsp_ovf   <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_ptr       <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_id;
        r_rsp_data  <= w_legal ? alu_s : '0;
        r_rsp_zero  <= w_legal & alu_zero;
        r_rsp_ovf   <= w_legal & alu_ovf;
        r_rsp_err   <= ~w_legal;
      end
      if (w_done) begin
        r_rsp_valid <= 1'b0;
        r_ptr       <= ~r_rsp_id;
      end
    end
  end

  // Ready is combinational from state; gate with reset so it is 0 while held.
  assign req0_ready = w_gnt0 & rst_n;
  assign req1_ready = w_gnt1 & rst_n;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_ctrl   = r_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_data   = r_rsp_data;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_ovf    = r_rsp_ovf;
  assign rsp_err    = r_rsp_err;

`ifdef ALU16_ARB_PERF_CNT_EN
  logic [15:0] r_cnt0;
  logic [15:0] r_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_done) begin
      if (!r_rsp_id && r_cnt0 != 16'hFFFF) r_cnt0 <= r_cnt0 + 16'd1;
      if ( r_rsp_id && r_cnt1 != 16'hFFFF) r_cnt1 <= r_cnt1 + 16'd1;
    end
  end

  assign perf_cnt0 = r_cnt0;
  assign perf_cnt1 = r_cnt1;
`endif

endmodule

// File: doc/alu16_arbiter.md
Name: alu16_arbiter

Overview:
- Shares one combinational 16-bit ALU between two requesters with round-robin arbitration.
- Each request carries operands plus a 4-bit ALU control code. The block latches the request, drives the ALU for one cycle, registers S/Zero/Overflow and returns them on a single response channel tagged with the requester ID.
- Sits between the datapath's operand sources and the ALU instance.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU.
- OPC_W, 4, ALU control code width.
- MAX_OPC, 8, highest legal control code (0 AND, 1 OR, 2 ADD, 3 SUB, 4 ANOT, 5 BNOT, 6 INC, 7 DEC, 8 SLT).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  requester 0 request accepted this cycle
- req0_a  in  WIDTH  operand A
- req0_b  in  WIDTH  operand B
- req0_op  in  OPC_W  ALU control code
- req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0, for requester 1
- alu_a  out  WIDTH  to ALU A
- alu_b  out  WIDTH  to ALU B
- alu_ctrl  out  OPC_W  to ALU control
- alu_s  in  WIDTH  ALU result
- alu_zero  in  1  ALU Zero flag
- alu_ovf  in  1  ALU Overflow flag
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the op
- rsp_data  out  WIDTH  registered result
- rsp_zero  out  1  registered Zero flag
- rsp_ovf  out  1  registered Overflow flag
- rsp_err  out  1  op code was illegal

Behaviour:
- Reset (rst_n low, asynchronous):
  - State is IDLE and the priority pointer is 0.
  - All outputs are 0: req*_ready, rsp_*, alu_a, alu_b, alu_ctrl.
  - A reset in any state aborts the in-flight op; no response is produced.
- FSM states: IDLE -> ISSUE -> RESP -> IDLE. Exactly one op is in flight; there is no pipelining.
- IDLE:
  - Only one valid: grant that requester.
  - Both valid: grant the requester named by the priority pointer.
  - Grant actions: assert its req*_ready combinationally in this cycle; latch a, b, op and the grant ID at the clock edge; go to ISSUE.
  - The requester may drop valid or change its operands after the handshake.
  - No valid: stay in IDLE.
  - req*_ready is never asserted outside IDLE, and never for both requesters at once.
- ISSUE (1 cycle):
  - alu_a, alu_b, alu_ctrl are driven from the latched registers. They hold their values in all other states and are not zeroed after an op.
  - At the edge:
    - op <= MAX_OPC: rsp_data <= alu_s, rsp_zero <= alu_zero, rsp_ovf <= alu_ovf, rsp_err <= 0.
    - op > MAX_OPC: rsp_data <= 0, rsp_zero <= 0, rsp_ovf <= 0, rsp_err <= 1.
  - rsp_id <= latched grant ID; rsp_valid <= 1; go to RESP.
- RESP:
  - rsp_valid and all rsp_* fields stay stable until rsp_ready = 1 at a clock edge.
  - On that edge: rsp_valid <= 0; priority pointer <= ~rsp_id (the other requester gets priority); go to IDLE.
- Timing and fairness:
  - Latency from request acceptance to rsp_valid is 2 cycles.
  - Best-case throughput is one op per 3 cycles.
  - Under continuous contention the grants alternate 0,1,0,1.
- Widths and flags: no widening; the result is exactly WIDTH bits. Flags pass through from the ALU unchanged and are not reinterpreted per op.
- A request arriving while busy waits with valid held high and ready low; it is not lost.

Optional Feature:
- Macro: ALU16_ARB_PERF_CNT_EN.
- Defined:
  - Adds output ports perf_cnt0 and perf_cnt1 (16 bits each).
  - Each counts completed responses (rsp_valid & rsp_ready) for its ID.
  - Counters saturate at 16'hFFFF and are cleared by rst_n.
- Not defined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Single ADD: req0 a=16'h0003 b=16'h0004 op=2, rsp_ready=1 -> rsp_valid 2 cycles after accept; rsp_data=16'h0007, zero=0, ovf=0, err=0, id=0.
- Contention: both valid every cycle; req0 SUB 5-5; req1 INC 16'hFFFF -> grants alternate 0,1,0,1. Responses are {id0, data 0, zero 1} and {id1, data 16'h0000, zero 1, ovf 0}; ready is never asserted to both at once.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp fields stable, no new grant, req1_ready stays 0. Releasing rsp_ready completes the response and IDLE grants next cycle.
- Illegal op: req1 op=4'hC a=16'h1234 -> rsp_err=1, rsp_data=0, id=1.
- Reset mid-op: assert rst_n low during ISSUE -> all outputs 0 immediately and no response after release. The next req0 request is granted first.
- With ALU16_ARB_PERF_CNT_EN: 3 responses to id0 and 1 to id1 -> perf_cnt0=3, perf_cnt1=1.
